// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation and a first-word-fall-through byte FIFO.
// Latency: valid_out rises one cycle after the stop-bit sample; backpressure: FIFO full drops new bytes and sets sticky overflow_out.
module uart_byte_rx #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   input  logic       ready_in,
   output logic       frame_err_out,
   output logic       overflow_out,
   output logic       busy_out
);

   localparam int CLKS_PER_TICK = CLK_HZ / (BAUD * 16);
   localparam int TW            = $clog2(CLKS_PER_TICK);
   localparam int AW            = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic          sync1;
   logic          rx_s;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    sub_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [2:0]    state;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic          empty;
   logic          full;
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [7:0]    mem [FIFO_DEPTH];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= data_in;
         rx_s  <= sync1;
      end
   end

   assign tick = (tick_cnt == TW'(CLKS_PER_TICK - 1));

   // sub_cnt counts ticks within the current bit; START checks at tick 8, later bits every 16.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= S_IDLE;
         tick_cnt      <= '0;
         sub_cnt       <= 4'd0;
         bit_idx       <= 3'd0;
         shift         <= 8'h00;
         frame_err_out <= 1'b0;
      end else begin
         frame_err_out <= 1'b0;
         tick_cnt      <= tick ? '0 : tick_cnt + TW'(1);
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state    <= S_START;
                  tick_cnt <= '0;
                  sub_cnt  <= 4'd0;
               end
            end
            S_START: begin
               if (tick) begin
                  if (sub_cnt == 4'd7) begin
                     sub_cnt <= 4'd0;
                     bit_idx <= 3'd0;
                     state   <= rx_s ? S_IDLE : S_DATA;
                  end else begin
                     sub_cnt <= sub_cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  sub_cnt <= sub_cnt + 4'd1;
                  if (sub_cnt == 4'd15) begin
                     shift[bit_idx] <= rx_s;
                     bit_idx        <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) state <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (tick) begin
                  sub_cnt <= sub_cnt + 4'd1;
                  if (sub_cnt == 4'd15) begin
                     if (rx_s) begin
                        state <= S_IDLE;
                     end else begin
                        frame_err_out <= 1'b1;
                        state         <= S_WAIT_HIGH;
                     end
                  end
               end
            end
            S_WAIT_HIGH: begin
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy_out = (state != S_IDLE);
   assign push     = (state == S_STOP) && tick && (sub_cnt == 4'd15) && rx_s;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign valid_out = !empty;
   assign pop       = valid_out && ready_in;
   // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
   assign wr_en     = push && (!full || pop);
   assign data_out  = valid_out ? mem[rd_ptr[AW-1:0]] : 8'h00;

   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= shift;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         overflow_out <= 1'b0;
      end else begin
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (push && !wr_en) overflow_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: vector table, hand-written corner sequences and a randomized run against a byte-queue model.
module tb_uart_byte_rx;

   localparam int BIT      = 160;
   localparam int FRAME    = 10 * BIT;
   // line falls #1 after edge k; stop sample lands on edge k+3+1520, valid visible after it
   localparam int STOP_LAT = 1523;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_in = 1'b1;
   logic       man_ready = 1'b0;
   logic       rnd_ready = 1'b0;
   bit         rnd_mode = 1'b0;
   logic       ready_in;
   logic [7:0] data_out;
   logic       valid_out, frame_err_out, overflow_out, busy_out;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int rise_cyc = -1;
   int ferr_cnt = 0;
   logic valid_q = 1'b0;
   bit sb_on = 1'b0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic [7:0] d;
      logic       stp;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;
   vec_t tbl [6];

   assign ready_in = rnd_mode ? rnd_ready : man_ready;

   uart_byte_rx #(.CLK_HZ(1_600_000), .BAUD(10_000), .FIFO_DEPTH(4)) dut (
      .clk_in(clk), .rst_in(rst), .data_in(data_in), .data_out(data_out),
      .valid_out(valid_out), .ready_in(ready_in), .frame_err_out(frame_err_out),
      .overflow_out(overflow_out), .busy_out(busy_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always begin
      @(posedge clk);
      #1 rnd_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (frame_err_out) ferr_cnt++;
      if (valid_out && !valid_q) rise_cyc = cyc;
      valid_q = valid_out;
      if (sb_on && valid_out && ready_in) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra actual=%0h required=none", data_out);
         end else begin
            chk("sb_data", int'(data_out), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      data_in = 1'b1;
      man_ready = 1'b0;
      tick_wait(3);
      rst = 1'b0;
      tick_wait(3);
   endtask

   // Drives one frame; pop_at pulses ready for one cycle, stop_at aborts early (-1 = unused).
   task automatic send(input logic [7:0] d, input logic stp, input int pop_at, input int stop_at);
      logic [9:0] fr;
      int n;
      fr = {stp, d, 1'b0};
      n = (stop_at >= 0) ? stop_at : FRAME;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) t0 = cyc;
         data_in = fr[i / BIT];
         if (pop_at >= 0 && i == pop_at) man_ready = 1'b1;
         if (pop_at >= 0 && i == pop_at + 1) man_ready = 1'b0;
      end
   endtask

   task automatic drain(input string nm);
      sb_on = 1'b1;
      @(posedge clk);
      #1 man_ready = 1'b1;
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
      #1 man_ready = 1'b0;
      sb_on = 1'b0;
      chk({nm, "_left"}, exp_q.size(), 0);
      exp_q.delete();
      chk({nm, "_empty"}, int'(valid_out), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, k, n_ferr, gap;
      logic [7:0] d;
      logic stp;

      tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
      tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      tbl[3] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1};
      tbl[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
      tbl[5] = '{8'h6E, 1'b1, 1'b1, 8'h6E, 0};

      tick_wait(2);
      chk("rst_valid", int'(valid_out), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_ferr", int'(frame_err_out), 0);
      chk("rst_ovf", int'(overflow_out), 0);
      chk("rst_busy", int'(busy_out), 0);
      do_reset();

      foreach (tbl[i]) begin
         f0 = ferr_cnt;
         rise_cyc = -1;
         send(tbl[i].d, tbl[i].stp, -1, -1);
         data_in = 1'b1;
         tick_wait(20);
         chk($sformatf("tbl%0d_valid", i), int'(valid_out), int'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            chk($sformatf("tbl%0d_data", i), int'(data_out), int'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_lat", i), rise_cyc - t0, STOP_LAT);
         end
         chk($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
         man_ready = 1'b1;
         tick_wait(1);
         man_ready = 1'b0;
         chk($sformatf("tbl%0d_popped", i), int'(valid_out), 0);
      end

      // start glitch shorter than half a bit
      f0 = ferr_cnt;
      @(posedge clk);
      #1 data_in = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (i == 40) data_in = 1'b1;
         if (i == 10) chk("glitch_busy_early", int'(busy_out), 1);
         if (i == 80) chk("glitch_busy_mid", int'(busy_out), 1);
         if (i == 85) chk("glitch_idle", int'(busy_out), 0);
      end
      chk("glitch_valid", int'(valid_out), 0);
      chk("glitch_ferr", ferr_cnt - f0, 0);

      // framing error followed by a held break
      f0 = ferr_cnt;
      send(8'h3C, 1'b0, -1, -1);
      tick_wait(3 * BIT);
      chk("break_busy", int'(busy_out), 1);
      chk("break_ferr", ferr_cnt - f0, 1);
      chk("break_valid", int'(valid_out), 0);
      data_in = 1'b1;
      tick_wait(5);
      chk("break_idle", int'(busy_out), 0);

      // overflow: five back-to-back bytes into a 4-deep FIFO
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, -1, -1);
      chk("ovf4_valid", int'(valid_out), 1);
      chk("ovf4_flag", int'(overflow_out), 0);
      send(8'h05, 1'b1, -1, -1);
      chk("ovf5_flag", int'(overflow_out), 1);
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      drain("ovf_drain");
      chk("ovf_sticky", int'(overflow_out), 1);
      do_reset();
      chk("ovf_cleared", int'(overflow_out), 0);

      // pop coincident with the push into a full FIFO
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, -1, -1);
      send(8'h05, 1'b1, STOP_LAT - 1, -1);
      chk("pp_ovf", int'(overflow_out), 0);
      for (int i = 2; i <= 5; i++) exp_q.push_back(8'(i));
      drain("pp_drain");

      // reset during data bit 3
      send(8'h77, 1'b1, -1, -1);
      send(8'h5A, 1'b1, -1, 700);
      chk("mid_busy", int'(busy_out), 1);
      chk("mid_valid", int'(valid_out), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", int'(valid_out), 0);
      chk("mid_rst_data", int'(data_out), 0);
      chk("mid_rst_busy", int'(busy_out), 0);
      chk("mid_rst_ferr", int'(frame_err_out), 0);
      chk("mid_rst_ovf", int'(overflow_out), 0);
      data_in = 1'b1;
      tick_wait(3);
      rst = 1'b0;
      tick_wait(5);
      chk("mid_after_valid", int'(valid_out), 0);
      f0 = ferr_cnt;
      send(8'h5A, 1'b1, -1, -1);
      tick_wait(5);
      chk("mid_new_valid", int'(valid_out), 1);
      chk("mid_new_data", int'(data_out), 8'h5A);
      chk("mid_new_ferr", ferr_cnt - f0, 0);
      exp_q.push_back(8'h5A);
      drain("mid_drain");

      // randomized frames, random consumer, byte-queue model
      f0 = ferr_cnt;
      n_ferr = 0;
      sb_on = 1'b1;
      rnd_mode = 1'b1;
      for (int n = 0; n < 10; n++) begin
         d = 8'($urandom_range(0, 255));
         stp = ($urandom_range(0, 4) != 0);
         if (stp) exp_q.push_back(d);
         else n_ferr++;
         send(d, stp, -1, -1);
         data_in = 1'b1;
         gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 400));
         if (!stp && gap < 2) gap = 2;
         if (gap > 0) tick_wait(gap);
      end
      k = 0;
      while (k < 400 && exp_q.size() != 0) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("rand_left", exp_q.size(), 0);
      rnd_mode = 1'b0;
      sb_on = 1'b0;
      chk("rand_ferr", ferr_cnt - f0, n_ferr);
      chk("rand_ovf", int'(overflow_out), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
